uart_tx_buf: RTL and testbench

//  Buffered UART transmitter, 8N1/8N2, LSB first. Accepts bytes from the core side

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_fifo.sv | 72 +++++++
 rtl/uart_tx_buf.sv | 148 ++++++++++++++
 tb/tb_uart_tx_buf.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the FSM state encoding and the standard baud divisors.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Clocks per bit minus one: 115.2 kbps at 12 MHz and at 40 MHz
    localparam logic [11:0] UART_BEC_12M = 12'd103;
    localparam logic [11:0] UART_BEC_40M = 12'd346;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy output for the UART transmit queue.
// Read data is the entry at the read pointer; no read-ahead register.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int P_WIDTH      = UART_DATA_BITS,
    parameter int P_DEPTH_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [P_WIDTH-1:0]      wr_data,
    input  logic                    rd_en,
    output logic [P_WIDTH-1:0]      rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [P_DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 2 ** P_DEPTH_LOG2;
    localparam logic [P_DEPTH_LOG2:0] LVL_FULL = {1'b1, {P_DEPTH_LOG2{1'b0}}};
    localparam logic [P_DEPTH_LOG2:0] LVL_ONE = (P_DEPTH_LOG2 + 1)'(1);
    localparam logic [P_DEPTH_LOG2-1:0] PTR_ONE = P_DEPTH_LOG2'(1);

    logic [P_WIDTH-1:0]      mem_q [DEPTH];
    logic [P_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_DEPTH_LOG2:0]   level_q, level_d;
    logic                    push;
    logic                    pop;

    // A full FIFO refuses writes even when a pop happens the same cycle
    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Reset flushes the queue by clearing pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1/8N2 UART transmitter, LSB first, back-to-back frames.
// Bytes queue in a FIFO; the FSM pops them and drives a registered TXD.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter logic [11:0] P_BIT_END_COUNT   = UART_BEC_12M,
    parameter int          P_FIFO_DEPTH_LOG2 = 4,
    parameter int          P_STOP_BITS       = 1
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [7:0]                   TX_DATA,
    input  logic                         TX_VALID,
    output logic                         TX_READY,
    output logic                         TXD,
    output logic                         TX_BUSY,
    output logic                         TX_DONE,
    output logic [P_FIFO_DEPTH_LOG2:0]   FIFO_LEVEL
);

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic       LAST_STOP = (P_STOP_BITS == 2);

    uart_state_e                  state_q, state_d;
    logic [11:0]                  timer_q, timer_d;
    logic [2:0]                   bit_idx_q, bit_idx_d;
    logic                         stop_idx_q, stop_idx_d;
    logic [7:0]                   shift_q, shift_d;
    logic                         txd_q, txd_d;
    logic                         done_q, done_d;
    logic                         bit_end;
    logic                         load;
    logic                         fifo_pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [7:0]                   fifo_rd_data;
    logic [P_FIFO_DEPTH_LOG2:0]   fifo_level;

    uart_sync_fifo #(
        .P_WIDTH      (UART_DATA_BITS),
        .P_DEPTH_LOG2 (P_FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .wr_en   (TX_VALID),
        .wr_data (TX_DATA),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign bit_end    = (timer_q == P_BIT_END_COUNT);
    assign TX_READY   = !fifo_full;
    assign TXD        = txd_q;
    assign TX_DONE    = done_q;
    assign FIFO_LEVEL = fifo_level;
    assign TX_BUSY    = (fifo_level != '0) || (state_q != ST_IDLE);

    // Bit timer wraps each bit period and restarts on every frame load
    always_comb begin
        timer_d = bit_end ? 12'd0 : timer_q + 12'd1;
        if (load) timer_d = 12'd0;
    end

    // Frame sequencer: pop, start bit, data bits, stop bit(s)
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        load       = 1'b0;
        fifo_pop   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == LAST_STOP) begin
                        done_d = 1'b1;
                        if (!fifo_empty) load = 1'b1;
                        else state_d = ST_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            state_d  = ST_START;
        end
    end

    // Line level for the current state, registered one clock later
    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_q[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // State registers; reset forces the line idle-high at once
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            timer_q    <= 12'd0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            shift_q    <= 8'd0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: frame vectors, streaming,
// full-FIFO, reset, two-stop-bit and full-rate cases plus random traffic.
module tb_uart_tx_buf;

    typedef struct {
        int         inst;
        logic [7:0] b;
        int         t;
        bit         ok;
    } frame_t;

    typedef struct {
        int         inst;
        logic [7:0] b;
        int         t;
    } acc_t;

    typedef struct {
        int         inst;
        int         bc;
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] TX_DATA;
    logic [2:0] tx_valid;
    logic [2:0] rdy;
    logic [2:0] txd;
    logic [2:0] busy;
    logic [2:0] done;
    logic [4:0] lvl [3];

    int checks = 0;
    int failures = 0;
    int rdy_low = 0;
    int last_lvl = 0;
    int cyc = 0;
    int done_cnt [3] = '{0, 0, 0};

    frame_t frames0[$];
    frame_t frames1[$];
    frame_t frames2[$];
    acc_t   accs[$];
    vec_t   vecs[6];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) done_cnt[i] <= done_cnt[i] + int'(done[i]);
    end

    uart_tx_buf #(.P_BIT_END_COUNT(12'd3), .P_FIFO_DEPTH_LOG2(4), .P_STOP_BITS(1)) u0 (
        .CLK(CLK), .RESET(RESET), .TX_DATA(TX_DATA), .TX_VALID(tx_valid[0]),
        .TX_READY(rdy[0]), .TXD(txd[0]), .TX_BUSY(busy[0]), .TX_DONE(done[0]),
        .FIFO_LEVEL(lvl[0])
    );

    uart_tx_buf #(.P_BIT_END_COUNT(12'd3), .P_FIFO_DEPTH_LOG2(4), .P_STOP_BITS(2)) u1 (
        .CLK(CLK), .RESET(RESET), .TX_DATA(TX_DATA), .TX_VALID(tx_valid[1]),
        .TX_READY(rdy[1]), .TXD(txd[1]), .TX_BUSY(busy[1]), .TX_DONE(done[1]),
        .FIFO_LEVEL(lvl[1])
    );

    uart_tx_buf #(.P_BIT_END_COUNT(12'd103), .P_FIFO_DEPTH_LOG2(4), .P_STOP_BITS(1)) u2 (
        .CLK(CLK), .RESET(RESET), .TX_DATA(TX_DATA), .TX_VALID(tx_valid[2]),
        .TX_READY(rdy[2]), .TXD(txd[2]), .TX_BUSY(busy[2]), .TX_DONE(done[2]),
        .FIFO_LEVEL(lvl[2])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // UART receiver: detects a start bit, samples mid-bit, records the byte
    task automatic mon_step(input int inst, input int bc, output bit got, output frame_t f);
        got = 1'b0;
        f = '{inst, 8'h00, 0, 1'b0};
        @(negedge CLK);
        if (RESET === 1'b0 && txd[inst] === 1'b0) begin
            got = 1'b1;
            f.t = cyc;
            f.ok = 1'b1;
            for (int i = 0; i < 10; i++) begin
                repeat ((i == 0) ? bc / 2 : bc) @(negedge CLK);
                if (i == 0) begin
                    if (txd[inst] !== 1'b0) f.ok = 1'b0;
                end else if (i == 9) begin
                    if (txd[inst] !== 1'b1) f.ok = 1'b0;
                end else begin
                    f.b[i-1] = txd[inst];
                end
            end
        end
    endtask

    initial begin
        bit g;
        frame_t f;
        forever begin
            mon_step(0, 4, g, f);
            if (g) frames0.push_back(f);
        end
    end

    initial begin
        bit g;
        frame_t f;
        forever begin
            mon_step(1, 4, g, f);
            if (g) frames1.push_back(f);
        end
    end

    initial begin
        bit g;
        frame_t f;
        forever begin
            mon_step(2, 104, g, f);
            if (g) frames2.push_back(f);
        end
    end

    function automatic int fr_n(input int inst);
        case (inst)
            0:       return frames0.size();
            1:       return frames1.size();
            default: return frames2.size();
        endcase
    endfunction

    function automatic frame_t fr_at(input int inst, input int k);
        case (inst)
            0:       return frames0[k];
            1:       return frames1[k];
            default: return frames2[k];
        endcase
    endfunction

    // Offer one byte, hold valid until accepted; called and returns at a negedge
    task automatic put(input int inst, input logic [7:0] b, input int maxw);
        int n = 0;
        TX_DATA = b;
        tx_valid[inst] = 1'b1;
        while (rdy[inst] !== 1'b1 && n < maxw) begin
            rdy_low++;
            chk("full_when_not_ready", 32'(lvl[inst]), 16);
            @(negedge CLK);
            n++;
        end
        chk("put_ready", 32'(rdy[inst]), 1);
        if (rdy[inst] === 1'b1) begin
            last_lvl = int'(lvl[inst]);
            accs.push_back('{inst, b, cyc + 1});
        end
        @(negedge CLK);
        tx_valid[inst] = 1'b0;
    endtask

    // Timing model: a frame starts 2 clocks after acceptance or one pitch
    // after the previous frame start, whichever is later
    task automatic verify(input int inst, input int ab, input int fb, input int pitch, input string nm);
        acc_t e[$];
        frame_t f;
        int w = 0;
        int prev = -100000;
        int et;
        for (int i = ab; i < accs.size(); i++) begin
            if (accs[i].inst == inst) e.push_back(accs[i]);
        end
        while (fr_n(inst) - fb < e.size() && w < (e.size() + 2) * pitch + 400) begin
            @(negedge CLK);
            w++;
        end
        chk({nm, "_frames"}, fr_n(inst) - fb, e.size());
        for (int k = 0; k < e.size() && fb + k < fr_n(inst); k++) begin
            f = fr_at(inst, fb + k);
            et = (e[k].t + 2 > prev + pitch) ? e[k].t + 2 : prev + pitch;
            chk($sformatf("%s_byte%0d", nm, k), {f.ok, f.b}, {1'b1, e[k].b});
            chk($sformatf("%s_start%0d", nm, k), f.t, et);
            prev = et;
        end
        w = 0;
        while (busy[inst] !== 1'b0 && w < 4000) begin
            @(negedge CLK);
            w++;
        end
        chk({nm, "_idle"}, 32'(busy[inst]), 0);
        chk({nm, "_no_extra"}, fr_n(inst) - fb, e.size());
    endtask

    // Single byte into an idle transmitter, every clock of the frame compared
    task automatic run_vec(input vec_t v);
        int bad = 0;
        int dk = -1;
        int nd = 0;
        int inst = v.inst;
        int bc = v.bc;
        TX_DATA = v.data;
        tx_valid[inst] = 1'b1;
        chk("vec_ready", 32'(rdy[inst]), 1);
        @(negedge CLK);
        tx_valid[inst] = 1'b0;
        chk("vec_lvl_after_accept", 32'(lvl[inst]), 1);
        chk("vec_busy_after_accept", 32'(busy[inst]), 1);
        chk("vec_txd_before_pop", 32'(txd[inst]), 1);
        @(negedge CLK);
        chk("vec_lvl_after_pop", 32'(lvl[inst]), 0);
        chk("vec_txd_at_pop", 32'(txd[inst]), 1);
        @(negedge CLK);
        chk("vec_start_latency", 32'(txd[inst]), 0);
        for (int k = 1; k <= 10 * bc; k++) begin
            if (txd[inst] !== v.frame[(k - 1) / bc]) bad++;
            if (done[inst] === 1'b1) begin
                nd++;
                dk = k;
            end
            if (k < 10 * bc) @(negedge CLK);
        end
        chk($sformatf("vec_bits_%0h", v.data), bad, 0);
        chk($sformatf("vec_done_cycle_%0h", v.data), dk, 10 * bc);
        chk($sformatf("vec_done_count_%0h", v.data), nd, 1);
        @(negedge CLK);
        chk("vec_busy_end", 32'(busy[inst]), 0);
        chk("vec_done_end", 32'(done[inst]), 0);
    endtask

    initial begin
        int ab;
        int fb;
        int d0;
        int nlow;
        frame_t f;

        vecs[0] = '{0, 4, 8'h55, 10'h2AA};
        vecs[1] = '{0, 4, 8'hA3, 10'h346};
        vecs[2] = '{0, 4, 8'h00, 10'h200};
        vecs[3] = '{0, 4, 8'hFF, 10'h3FE};
        vecs[4] = '{0, 4, 8'h80, 10'h300};
        vecs[5] = '{2, 104, 8'h41, 10'h282};

        RESET = 1'b1;
        TX_DATA = 8'h00;
        tx_valid = 3'b000;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            chk("rst_txd", 32'(txd[i]), 1);
            chk("rst_level", 32'(lvl[i]), 0);
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_done", 32'(done[i]), 0);
            chk("rst_ready", 32'(rdy[i]), 1);
        end
        RESET = 1'b0;
        @(negedge CLK);

        fb = fr_n(2);
        for (int v = 0; v < 6; v++) begin
            run_vec(vecs[v]);
            repeat (4) @(negedge CLK);
        end
        chk("mon_115k_frames", fr_n(2) - fb, 1);
        if (fr_n(2) > fb) begin
            f = fr_at(2, fb);
            chk("mon_115k_char", {f.ok, f.b}, {1'b1, 8'h41});
        end

        ab = accs.size();
        fb = fr_n(0);
        rdy_low = 0;
        for (int b = 0; b < 19; b++) put(0, 8'(b), 200);
        chk("stream_ready_dropped", 32'(rdy_low > 0), 1);
        verify(0, ab, fb, 40, "stream");

        ab = accs.size();
        fb = fr_n(0);
        for (int i = 0; i < 17; i++) put(0, 8'h20 + 8'(i), 200);
        chk("fill_level", 32'(lvl[0]), 16);
        chk("fill_ready", 32'(rdy[0]), 0);
        rdy_low = 0;
        put(0, 8'h77, 200);
        chk("full_write_held", 32'(rdy_low > 0), 1);
        chk("full_level_after_pop", last_lvl, 15);
        chk("full_level_refilled", 32'(lvl[0]), 16);
        verify(0, ab, fb, 40, "full");

        put(0, 8'hA3, 10);
        for (int i = 0; i < 5; i++) put(0, 8'h11 + 8'(i), 10);
        chk("rst_setup_level", 32'(lvl[0]), 5);
        repeat (12) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("midrst_txd", 32'(txd[0]), 1);
        chk("midrst_level", 32'(lvl[0]), 0);
        chk("midrst_busy", 32'(busy[0]), 0);
        @(negedge CLK);
        RESET = 1'b0;
        nlow = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) nlow++;
        end
        chk("postrst_quiet", nlow, 0);
        ab = accs.size();
        fb = fr_n(0);
        put(0, 8'h5A, 10);
        verify(0, ab, fb, 40, "postrst");

        d0 = done_cnt[1];
        ab = accs.size();
        fb = fr_n(1);
        put(1, 8'hFF, 10);
        put(1, 8'h00, 10);
        verify(1, ab, fb, 44, "stop2");
        repeat (20) @(negedge CLK);
        chk("stop2_done_pulses", done_cnt[1] - d0, 2);

        ab = accs.size();
        fb = fr_n(0);
        for (int i = 0; i < 40; i++) begin
            put(0, 8'($urandom), 300);
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(30, 60)) @(negedge CLK);
            else repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        verify(0, ab, fb, 40, "random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
